// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode and FSM state encodings.
package acc_cpu_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_HI = 3'd1,
    S_FETCH_LO = 3'd2,
    S_DECODE   = 3'd3,
    S_MEM_RD   = 3'd4,
    S_MEM_WR   = 3'd5,
    S_HALTED   = 3'd6
  } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: computes the new accumulator for memory-read opcodes.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  input  opcode_e       opcode,
  output logic [DW-1:0] result
);

  always_comb begin
    // NOTE: default assignment first so every path drives result and no latch is inferred.
    result = acc;
    case (opcode)
      OP_ADD:  result = acc + operand;
      OP_AND:  result = acc & operand;
      OP_XOR:  result = acc ^ operand;
      OP_LDA:  result = operand;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: two-beat instruction fetch, single memory port with
// ready handshake, HALTED state with resume.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rdata,
  input  logic          ready,
  input  logic          resume,
  output logic          rd,
  output logic          wr,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          fetch,
  output logic          halt,
  output logic          zero
);

  localparam int IRW = OPW + AW;
  // Bits of ir filled by the low beat; the rest come from the high beat.
  localparam logic [IRW-1:0] LO_MASK = IRW'({DW{1'b1}});

  state_e        state;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic [IRW-1:0] ir;
  opcode_e       opcode;
  logic [AW-1:0] ir_addr;
  logic [DW-1:0] alu_result;

  assign opcode  = opcode_e'(ir[IRW-1:AW]);
  assign ir_addr = ir[AW-1:0];

  acc_cpu_alu #(.DW(DW)) u_alu (
    .acc     (acc),
    .operand (rdata),
    .opcode  (opcode),
    .result  (alu_result)
  );

  assign rd    = (state == S_FETCH_HI) || (state == S_FETCH_LO) || (state == S_MEM_RD);
  assign wr    = (state == S_MEM_WR);
  assign fetch = (state == S_FETCH_HI) || (state == S_FETCH_LO);
  assign halt  = (state == S_HALTED);
  assign addr  = ((state == S_MEM_RD) || (state == S_MEM_WR)) ? ir_addr : pc;
  assign wdata = acc;
  assign zero  = (acc == '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      acc   <= '0;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH_HI;
        S_FETCH_HI: if (ready) begin
          ir    <= IRW'({rdata, {DW{1'b0}}});
          pc    <= pc + AW'(1);
          state <= S_FETCH_LO;
        end
        S_FETCH_LO: if (ready) begin
          ir    <= (ir & ~LO_MASK) | IRW'(rdata);
          pc    <= pc + AW'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_HLT: state <= S_HALTED;
            OP_SKZ: begin
              if (zero) pc <= pc + AW'(2);
              state <= S_FETCH_HI;
            end
            OP_JMP: begin
              pc    <= ir_addr;
              state <= S_FETCH_HI;
            end
            OP_STO:  state <= S_MEM_WR;
            default: state <= S_MEM_RD;
          endcase
        end
        S_MEM_RD: if (ready) begin
          acc   <= alu_result;
          state <= S_FETCH_HI;
        end
        S_MEM_WR: if (ready) state <= S_FETCH_HI;
        S_HALTED: if (resume) state <= S_FETCH_HI;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: default 8/13 instance plus a 16/16 instance for wrap cases.
module tb_acc_cpu_core;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, LDA = 3'b101,
                         STO = 3'b110, JMP = 3'b111;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst, ready, resume;
  logic [7:0]  rdata, wdata;
  logic [12:0] addr;
  logic        rd, wr, fetch, halt, zero;
  logic [7:0]  mem8 [0:8191];
  assign rdata = mem8[addr];

  acc_cpu_core u_dut (
    .clk(clk), .rst(rst), .rdata(rdata), .ready(ready), .resume(resume),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .fetch(fetch), .halt(halt), .zero(zero)
  );

  // DW=16, AW=16 instance
  logic        rst16, ready16, resume16;
  logic [15:0] rdata16, wdata16, addr16;
  logic        rd16, wr16, fetch16, halt16, zero16;
  logic [15:0] mem16 [0:65535];
  assign rdata16 = mem16[addr16];

  acc_cpu_core #(.DW(16), .AW(16)) u_dut16 (
    .clk(clk), .rst(rst16), .rdata(rdata16), .ready(ready16), .resume(resume16),
    .rd(rd16), .wr(wr16), .addr(addr16), .wdata(wdata16), .fetch(fetch16), .halt(halt16),
    .zero(zero16)
  );

  // store log for the 8-bit instance
  int          st_cnt;
  logic [12:0] st_addr;
  logic [7:0]  st_data;
  always @(posedge clk) begin
    if (rst) begin
      st_cnt  <= 0;
      st_addr <= '0;
      st_data <= '0;
    end else if (wr && ready) begin
      st_cnt  <= st_cnt + 1;
      st_addr <= addr;
      st_data <= wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear8();
    for (int i = 0; i < 8192; i++) mem8[i] = 8'h00;
  endtask

  task automatic put8(input int pc, input logic [2:0] op, input logic [12:0] a);
    logic [15:0] w;
    w = {op, a};
    mem8[pc]     = w[15:8];
    mem8[pc + 1] = w[7:0];
  endtask

  task automatic start8();
    rst = 1'b1; ready = 1'b1; resume = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_halt8(input int budget, output int cyc);
    cyc = 0;
    while (!halt && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  int cyc;
  bit found;

  initial begin
    rst = 1'b1; ready = 1'b1; resume = 1'b0;
    rst16 = 1'b1; ready16 = 1'b1; resume16 = 1'b0;
    for (int i = 0; i < 65536; i++) mem16[i] = 16'h0000;

    // reset values
    clear8();
    step(); step();
    check("reset_outputs", {rd, wr, fetch, halt, zero}, 5'b00001);
    check("reset_addr", 32'(addr), 32'h0);
    check("reset_wdata", 32'(wdata), 32'h0);

    // LDA 10, ADD 11, STO 12, HLT: 0x05 + 0xFB wraps to 0x00
    put8(0, LDA, 13'd10); put8(2, ADD, 13'd11); put8(4, STO, 13'd12); put8(6, HLT, 13'd0);
    mem8[10] = 8'h05; mem8[11] = 8'hFB;
    start8();
    wait_halt8(100, cyc);
    check("prog1_halt", 32'(halt), 32'h1);
    check("prog1_cycles", 32'(cyc), 32'd16);
    check("prog1_zero", 32'(zero), 32'h1);
    check("prog1_pc", 32'(addr), 32'd8);
    check("prog1_store_cnt", 32'(st_cnt), 32'd1);
    check("prog1_store", {st_addr, st_data}, {13'd12, 8'h00});

    // stays halted without resume, then resume restarts after the HLT
    step(); step();
    check("halt_hold", {halt, rd, wr, fetch}, 4'b1000);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_fetch", {halt, fetch, rd}, 3'b011);
    check("resume_addr", 32'(addr), 32'd8);
    wait_halt8(20, cyc);
    check("resume_rehalt_cycles", 32'(cyc), 32'd3);
    check("resume_rehalt_pc", 32'(addr), 32'd10);

    // SKZ with acc==0 skips the JMP
    clear8();
    put8(0, SKZ, 13'd0); put8(2, JMP, 13'h40); put8(4, LDA, 13'd20); put8(6, HLT, 13'd0);
    mem8[20] = 8'h77;
    start8();
    wait_halt8(100, cyc);
    check("skz_taken_cycles", 32'(cyc), 32'd11);
    check("skz_taken_pc", 32'(addr), 32'd8);
    check("skz_taken_acc", 32'(wdata), 32'h77);

    // SKZ with acc!=0 falls through to the JMP
    clear8();
    put8(0, LDA, 13'd21); put8(2, SKZ, 13'd0); put8(4, JMP, 13'h40); put8(6, LDA, 13'd20);
    put8(8, HLT, 13'd0);
    mem8[20] = 8'h77; mem8[21] = 8'h33;
    start8();
    wait_halt8(100, cyc);
    check("skz_fall_cycles", 32'(cyc), 32'd14);
    check("skz_fall_pc", 32'(addr), 32'h42);
    check("skz_fall_acc", {zero, wdata}, {1'b0, 8'h33});

    // ready stalls in FETCH_LO and MEM_WR; resume ignored outside HALTED
    clear8();
    put8(0, LDA, 13'd10); put8(2, STO, 13'd12); put8(4, HLT, 13'd0);
    mem8[10] = 8'h5A;
    start8();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = fetch && (addr == 13'd1);
    end
    check("stall_reach_fetch_lo", 32'(found), 32'h1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_fetch_lo_hold", {rd, wr, fetch, addr}, {1'b1, 1'b0, 1'b1, 13'd1});
    end
    ready = 1'b1;
    step();
    check("stall_fetch_lo_release", {rd, wr, fetch, addr}, {1'b0, 1'b0, 1'b0, 13'd2});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = wr;
    end
    check("stall_reach_mem_wr", 32'(found), 32'h1);
    ready = 1'b0; resume = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_mem_wr_hold", {rd, wr, fetch, halt, addr, wdata},
            {1'b0, 1'b1, 1'b0, 1'b0, 13'd12, 8'h5A});
    end
    check("stall_no_store", 32'(st_cnt), 32'd0);
    resume = 1'b0; ready = 1'b1;
    step();
    check("stall_mem_wr_release", {wr, fetch, addr}, {1'b0, 1'b1, 13'd4});
    check("stall_store", {st_addr, st_data}, {13'd12, 8'h5A});
    wait_halt8(20, cyc);
    check("stall_halt_pc", {halt, addr}, {1'b1, 13'd6});

    // reset in the middle of a stalled MEM_RD
    clear8();
    put8(0, LDA, 13'd10); put8(2, ADD, 13'd11);
    mem8[10] = 8'h5A; mem8[11] = 8'h01;
    start8();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = rd && !fetch && (addr == 13'd11);
    end
    check("rst_reach_mem_rd", 32'(found), 32'h1);
    ready = 1'b0;
    check("rst_acc_before", 32'(wdata), 32'h5A);
    step();
    check("rst_mem_rd_hold", {rd, fetch, addr}, {1'b1, 1'b0, 13'd11});
    rst = 1'b1;
    step();
    check("rst_mid_outputs", {rd, wr, fetch, halt, zero}, 5'b00001);
    check("rst_mid_addr_acc", {addr, wdata}, {13'd0, 8'h00});
    rst = 1'b0; ready = 1'b1;
    step();
    check("rst_refetch", {fetch, rd, addr}, {1'b1, 1'b1, 13'd0});

    // DW=16/AW=16: ADD wrap and pc wrap through 0xFFFF
    mem16[0] = 16'h0005; mem16[1] = 16'h0100;   // LDA 0x100
    mem16[2] = 16'h0002; mem16[3] = 16'h0101;   // ADD 0x101
    mem16[4] = 16'h0007; mem16[5] = 16'hFFFF;   // JMP 0xFFFF
    mem16[16'h0100] = 16'hFFFF; mem16[16'h0101] = 16'h0002;
    step();
    rst16 = 1'b0;
    cyc = 0;
    while (!halt16 && cyc < 100) begin
      step();
      cyc++;
    end
    check("w16_cycles", 32'(cyc), 32'd15);
    check("w16_pc_wrap", {halt16, addr16}, {1'b1, 16'h0001});
    check("w16_add_wrap", {zero16, wdata16}, {1'b0, 16'h0001});
    check("w16_no_requests", {rd16, wr16, fetch16}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
